// File: rtl/serial_parity_pkg.sv
// Shared mode encodings, counter width and small helpers for the serial parity framer.
// Imported by the framer top and its bit-index counter.
package serial_parity_pkg;

   localparam int MODE_GEN      = 0;
   localparam int MODE_CHK      = 1;
   localparam int ERR_CNT_W     = 8;
   localparam int FRAME_LEN_MIN = 2;
   localparam int FRAME_LEN_MAX = 16;

   // Transmitted parity: the frame XOR folded with the even/odd selection.
   function automatic logic parity_bit(input logic frame_xor, input logic odd);
      return frame_xor ^ odd;
   endfunction

   // A checked frame is bad when its total XOR (data plus received parity) misses the target.
   function automatic logic parity_err(input logic frame_xor, input logic odd);
      return frame_xor != odd;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
      logic [ERR_CNT_W-1:0] result;
      if (value == {ERR_CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + ERR_CNT_W'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_frame_cnt.sv
// Bit-position counter for the serial parity framer.
// The last-bit strobe fires only on an edge that really completes a frame (EN set, no SYNC).
module serial_frame_cnt
   import serial_parity_pkg::*;
#(
   parameter int FRAME_LEN = 3,
   localparam int IDX_W    = $clog2(FRAME_LEN)
) (
   input  logic             C,
   input  logic             R,
   input  logic             EN,
   input  logic             SYNC,
   output logic [IDX_W-1:0] index,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_next_s;

   // Next index: SYNC restarts the frame, and a bit accepted with it already counts as bit 0.
   always_comb begin
      idx_next_s = idx_r;
      if (SYNC) begin
         if (EN) begin
            idx_next_s = IDX_ONE;
         end else begin
            idx_next_s = IDX_ZERO;
         end
      end else if (EN) begin
         if (idx_r == LAST_IDX) begin
            idx_next_s = IDX_ZERO;
         end else begin
            idx_next_s = idx_r + IDX_ONE;
         end
      end else begin
         idx_next_s = idx_r;
      end
   end

   // Index register.
   always_ff @(posedge C) begin
      if (R) begin
         idx_r <= IDX_ZERO;
      end else begin
         idx_r <= idx_next_s;
      end
   end

   assign index = idx_r;
   assign last  = EN & ~SYNC & (idx_r == LAST_IDX);

endmodule

// File: rtl/serial_parity_frame.sv
// Serial parity framer: collects FRAME_LEN bits MSB first and either generates
// their parity or checks a received parity bit, counting bad frames.
module serial_parity_frame
   import serial_parity_pkg::*;
#(
   parameter int FRAME_LEN = 3,
   parameter int ODD       = 0,
   parameter int MODE      = MODE_GEN
) (
   input  logic                 C,
   input  logic                 R,
   input  logic                 D,
   input  logic                 EN,
   input  logic                 SYNC,
   output logic [FRAME_LEN-1:0] WORD,
   output logic                 P,
   output logic                 P_VLD,
   output logic                 ERR,
   output logic [ERR_CNT_W-1:0] ERR_CNT
);

   localparam int   IDX_W    = $clog2(FRAME_LEN);
   localparam logic ODD_BIT  = (ODD != 0);
   localparam logic CHK_MODE = (MODE == MODE_CHK);
   localparam logic [IDX_W-1:0]     IDX_ZERO   = {IDX_W{1'b0}};
   localparam logic [FRAME_LEN-1:0] FRAME_ZERO = {FRAME_LEN{1'b0}};

   logic [IDX_W-1:0]     idx_s;
   logic                 last_s;
   logic [FRAME_LEN-1:0] shift_r;
   logic [FRAME_LEN-1:0] shift_next_s;
   logic                 acc_r;
   logic                 acc_next_s;
   logic                 err_next_s;
   logic [FRAME_LEN-1:0] word_r;
   logic                 p_r;
   logic                 p_vld_r;
   logic                 err_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;

   serial_frame_cnt #(
      .FRAME_LEN(FRAME_LEN)
   ) u_cnt (
      .C    (C),
      .R    (R),
      .EN   (EN),
      .SYNC (SYNC),
      .index(idx_s),
      .last (last_s)
   );

   // Fold the incoming bit into the running frame; index 0 starts the XOR afresh,
   // so leftovers of a finished frame never leak into the next one.
   always_comb begin
      shift_next_s = shift_r;
      acc_next_s   = acc_r;
      if (SYNC) begin
         if (EN) begin
            shift_next_s = {{(FRAME_LEN-1){1'b0}}, D};
            acc_next_s   = D;
         end else begin
            shift_next_s = FRAME_ZERO;
            acc_next_s   = 1'b0;
         end
      end else if (EN) begin
         shift_next_s = {shift_r[FRAME_LEN-2:0], D};
         if (idx_s == IDX_ZERO) begin
            acc_next_s = D;
         end else begin
            acc_next_s = acc_r ^ D;
         end
      end else begin
         shift_next_s = shift_r;
         acc_next_s   = acc_r;
      end
   end

   // Error verdict for a frame completing on this edge; generator mode never flags.
   always_comb begin
      err_next_s = 1'b0;
      if (CHK_MODE) begin
         err_next_s = parity_err(acc_next_s, ODD_BIT);
      end else begin
         err_next_s = 1'b0;
      end
   end

   // Frame accumulator state.
   always_ff @(posedge C) begin
      if (R) begin
         shift_r <= FRAME_ZERO;
         acc_r   <= 1'b0;
      end else begin
         shift_r <= shift_next_s;
         acc_r   <= acc_next_s;
      end
   end

   // Result registers: loaded only when a frame completes, held otherwise.
   always_ff @(posedge C) begin
      if (R) begin
         word_r  <= FRAME_ZERO;
         p_r     <= 1'b0;
         err_r   <= 1'b0;
         p_vld_r <= 1'b0;
      end else begin
         p_vld_r <= last_s;
         if (last_s) begin
            word_r <= shift_next_s;
            p_r    <= parity_bit(acc_next_s, ODD_BIT);
            err_r  <= err_next_s;
         end else begin
            word_r <= word_r;
            p_r    <= p_r;
            err_r  <= err_r;
         end
      end
   end

   // Saturating count of frames that completed with a parity error.
   always_ff @(posedge C) begin
      if (R) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (last_s && err_next_s) begin
         err_cnt_r <= sat_inc(err_cnt_r);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign WORD    = word_r;
   assign P       = p_r;
   assign P_VLD   = p_vld_r;
   assign ERR     = err_r;
   assign ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_serial_parity_frame.sv
// Bench for serial_parity_frame: directed vector table, hand-written error-count
// sequence and random traffic, all checked against a frame-level reference model.
module tb_serial_parity_frame;
   import serial_parity_pkg::*;

   logic C = 1'b0;
   logic R = 1'b1;
   logic D = 1'b0;
   logic EN = 1'b0;
   logic SYNC = 1'b0;

   always #5 C = ~C;

   logic [2:0] word_g, word_c;
   logic [4:0] word_o;
   logic p_g, p_c, p_o, v_g, v_c, v_o, e_g, e_c, e_o;
   logic [7:0] c_g, c_c, c_o;

   serial_parity_frame #(.FRAME_LEN(3), .ODD(0), .MODE(MODE_GEN)) u_gen (
      .C(C), .R(R), .D(D), .EN(EN), .SYNC(SYNC),
      .WORD(word_g), .P(p_g), .P_VLD(v_g), .ERR(e_g), .ERR_CNT(c_g));
   serial_parity_frame #(.FRAME_LEN(3), .ODD(0), .MODE(MODE_CHK)) u_chk (
      .C(C), .R(R), .D(D), .EN(EN), .SYNC(SYNC),
      .WORD(word_c), .P(p_c), .P_VLD(v_c), .ERR(e_c), .ERR_CNT(c_c));
   serial_parity_frame #(.FRAME_LEN(5), .ODD(1), .MODE(MODE_CHK)) u_odd (
      .C(C), .R(R), .D(D), .EN(EN), .SYNC(SYNC),
      .WORD(word_o), .P(p_o), .P_VLD(v_o), .ERR(e_o), .ERR_CNT(c_o));

   logic [15:0] a_word [3];
   logic        a_p [3];
   logic        a_vld [3];
   logic        a_err [3];
   logic [7:0]  a_cnt [3];
   assign a_word[0] = 16'(word_g);
   assign a_word[1] = 16'(word_c);
   assign a_word[2] = 16'(word_o);
   assign a_p[0] = p_g;  assign a_p[1] = p_c;  assign a_p[2] = p_o;
   assign a_vld[0] = v_g; assign a_vld[1] = v_c; assign a_vld[2] = v_o;
   assign a_err[0] = e_g; assign a_err[1] = e_c; assign a_err[2] = e_o;
   assign a_cnt[0] = c_g; assign a_cnt[1] = c_c; assign a_cnt[2] = c_o;

   // Reference model: frame value built arithmetically, parity from the count of ones.
   int m_len [3]  = '{3, 3, 5};
   int m_odd [3]  = '{0, 0, 1};
   int m_mode [3] = '{0, 1, 1};
   int fill [3]   = '{0, 0, 0};
   int val [3]    = '{0, 0, 0};
   int e_word [3] = '{0, 0, 0};
   int e_p [3]    = '{0, 0, 0};
   int e_vld [3]  = '{0, 0, 0};
   int e_err [3]  = '{0, 0, 0};
   int e_cnt [3]  = '{0, 0, 0};

   int total = 0;
   int bad = 0;

   typedef struct {
      logic r, en, sync, d;
      logic [2:0] word;
      logic p, vld;
   } vec_t;
   vec_t tbl [35];

   function automatic vec_t mk(input logic r, input logic en, input logic sync, input logic d,
                               input logic [2:0] w, input logic p, input logic vld);
      vec_t v;
      v.r = r; v.en = en; v.sync = sync; v.d = d; v.word = w; v.p = p; v.vld = vld;
      return v;
   endfunction

   task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic en, input logic sync, input logic d);
      int ones;
      for (int k = 0; k < 3; k++) begin
         e_vld[k] = 0;
         if (r) begin
            fill[k] = 0; val[k] = 0; e_word[k] = 0; e_p[k] = 0; e_err[k] = 0; e_cnt[k] = 0;
         end else if (sync) begin
            fill[k] = en ? 1 : 0;
            val[k]  = en ? int'(d) : 0;
         end else if (en) begin
            val[k]  = val[k] * 2 + int'(d);
            fill[k] = fill[k] + 1;
            if (fill[k] == m_len[k]) begin
               ones      = $countones(val[k]);
               e_word[k] = val[k];
               e_p[k]    = (ones % 2) ^ m_odd[k];
               e_err[k]  = (m_mode[k] == 1 && (ones % 2) != m_odd[k]) ? 1 : 0;
               if (e_err[k] == 1 && e_cnt[k] < 255) e_cnt[k] = e_cnt[k] + 1;
               e_vld[k]  = 1;
               fill[k]   = 0;
               val[k]    = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         check("word",    k, a_word[k],        16'(e_word[k]));
         check("p",       k, 16'(a_p[k]),      16'(e_p[k]));
         check("p_vld",   k, 16'(a_vld[k]),    16'(e_vld[k]));
         check("err",     k, 16'(a_err[k]),    16'(e_err[k]));
         check("err_cnt", k, 16'(a_cnt[k]),    16'(e_cnt[k]));
      end
   endtask

   task automatic cycle(input logic r, input logic en, input logic sync, input logic d);
      R = r; EN = en; SYNC = sync; D = d;
      @(posedge C);
      model_step(r, en, sync, d);
      #1;
      compare_all();
   endtask

   initial begin
      // Directed table for the FRAME_LEN=3 even generator.
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1);
      tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1);
      tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0);
      tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1);
      tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
      tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0);
      for (int i = 12; i < 17; i++) tbl[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
      tbl[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);
      tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
      tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
      tbl[20] = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
      tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0);
      tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1);
      tbl[23] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
      tbl[24] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
      tbl[25] = mk(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[26] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[27] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      tbl[28] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1);
      tbl[29] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0);
      tbl[30] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0);
      tbl[31] = mk(1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
      tbl[32] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0);
      tbl[33] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);
      tbl[34] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1);

      for (int i = 0; i < 35; i++) begin
         cycle(tbl[i].r, tbl[i].en, tbl[i].sync, tbl[i].d);
         check("tbl_word",  i, 16'(word_g), 16'(tbl[i].word));
         check("tbl_p",     i, 16'(p_g),    16'(tbl[i].p));
         check("tbl_p_vld", i, 16'(v_g),    16'(tbl[i].vld));
      end

      // Checker-mode error flag and saturating error count.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("chk_rst_cnt", 0, 16'(c_c), 16'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      check("chk_err_111", 0, 16'(e_c), 16'd1);
      check("chk_cnt_111", 0, 16'(c_c), 16'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check("chk_err_110", 0, 16'(e_c), 16'd0);
      check("chk_cnt_110", 0, 16'(c_c), 16'd1);
      check("chk_vld_110", 0, 16'(v_c), 16'd1);
      for (int f = 0; f < 300; f++) begin
         for (int b = 0; b < 3; b++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      end
      check("chk_cnt_sat", 0, 16'(c_c), 16'd255);
      check("chk_err_sat", 0, 16'(e_c), 16'd1);
      check("gen_cnt_zero", 0, 16'(c_g), 16'd0);

      // Random traffic with gaps, re-alignment and occasional reset.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
               ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
               $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_parity_frame.md
SERIAL_PARITY_FRAME -- requirements
Module: serial_parity_frame

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 3; bits per frame; legal range 2..16.
REQ-002 SHALL have parameter ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have parameter MODE, default 0; 0 generates parity, 1 checks parity (last frame bit is the received parity bit).
REQ-004 SHALL have port C, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-005 SHALL have port R, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port D, input, 1 bit; serial data bit.
REQ-007 SHALL have port EN, input, 1 bit; D is accepted on a rising edge of C only when EN=1.
REQ-008 SHALL have port SYNC, input, 1 bit; frame re-alignment request.
REQ-009 SHALL have port WORD, output, FRAME_LEN bits; last completed frame, first-received bit in MSB.
REQ-010 SHALL have port P, output, 1 bit; parity of the last completed frame.
REQ-011 SHALL have port P_VLD, output, 1 bit; one-cycle pulse marking a newly completed frame.
REQ-012 SHALL have port ERR, output, 1 bit; parity error flag for the last completed frame.
REQ-013 SHALL have port ERR_CNT, output, 8 bits; count of frames with ERR=1.

Function
REQ-014 SHALL keep a bit index 0..FRAME_LEN-1 that advances by one per accepted bit and wraps from FRAME_LEN-1 to 0.
REQ-015 SHALL shift accepted bits into an internal register, MSB first, and keep a running XOR of the accepted bits.
REQ-016 SHALL, on the edge accepting the bit at index FRAME_LEN-1, load WORD, P and ERR and assert P_VLD, so results are visible one cycle after the last bit.
REQ-017 SHALL hold P_VLD high for exactly one cycle per completed frame, even with back-to-back frames and EN held high.
REQ-018 SHALL compute P as the XOR of all FRAME_LEN bits, XORed with ODD.
REQ-019 SHALL, when MODE=1, set ERR=1 when the XOR of all FRAME_LEN bits differs from ODD, otherwise ERR=0.
REQ-020 SHALL, when MODE=0, hold ERR=0 and ERR_CNT=0 permanently.
REQ-021 SHALL hold WORD, P and ERR stable between completed frames.
REQ-022 SHALL not advance the index or accumulator when EN=0; gaps of any length are transparent.
REQ-023 SHALL, when SYNC=1 and EN=1, discard any partial frame and take D as bit 0 of a new frame, with no P_VLD for the discarded frame.
REQ-024 SHALL, when SYNC=1 and EN=0, clear the index and accumulator, with no P_VLD.
REQ-025 SHALL, when FRAME_LEN bits complete on the same edge as SYNC=1 with EN=1, give SYNC priority and discard the partial frame.
REQ-026 SHALL increment ERR_CNT on each frame completing with ERR=1 and saturate at 255.

Reset
REQ-027 SHALL, while R=1 at a rising edge of C, clear WORD, P, P_VLD, ERR, ERR_CNT, the index and the accumulator to 0.
REQ-028 SHALL give R priority over EN and SYNC; a frame in progress when R is asserted is discarded.
REQ-029 SHALL accept the first bit after reset release as bit 0.

Structure
REQ-030 SHALL place the MODE encodings (MODE_GEN=0, MODE_CHK=1) and the ERR_CNT width constant (8) in shared package serial_parity_pkg.
REQ-031 SHALL implement the bit index as sub-module serial_frame_cnt (parameter FRAME_LEN; inputs C, R, EN, SYNC; outputs index and last-bit strobe).

Verification
REQ-032 SHALL cover: FRAME_LEN=3, ODD=0, MODE=0, EN=1, bits 1,0,1 -> WORD=3'b101, P=0, P_VLD high one cycle after bit 3.
REQ-033 SHALL cover: the same configuration with bits 1,1,1 then 0,1,1 back-to-back -> P=1 then P=0, with two P_VLD pulses 3 cycles apart.
REQ-034 SHALL cover: bits 1,0 with EN, then 5 cycles at EN=0, then bit 0 -> WORD=3'b100, P=1, P_VLD exactly once.
REQ-035 SHALL cover: bits 1,1, then SYNC=1, EN=1, D=0, then bits 0,1 -> no pulse for the partial frame, then WORD=3'b001, P=1.
REQ-036 SHALL cover: MODE=1, ODD=0, frames 1,1,1 and 1,1,0 -> ERR=1 with ERR_CNT=1, then ERR=0 with ERR_CNT=1; 300 bad frames -> ERR_CNT=255.
REQ-037 SHALL cover: R=1 after two bits of a frame -> all outputs 0 on the next cycle; the next 3 bits form a complete frame.
